// File: rtl/wb_arb_pkg.sv
// Shared defaults and types for the register-file writeback arbiter.
// Used by regfile_wb_arbiter and wb_arb_starve_ctr.
package wb_arb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   // Width of the req1 starvation wait counter; STARVE_LIMIT must fit in it.
   localparam int WAIT_CNT_W = 4;
   localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = '1;

   typedef enum logic [0:0] {
      NORMAL = 1'b0,
      FORCE1 = 1'b1
   } arb_state_t;

endpackage

// File: rtl/wb_arb_starve_ctr.sv
// req1 starvation tracker: wait counter plus NORMAL/FORCE1 state.
// Present only with WB_ARB_STARVE_EN defined; otherwise force1/starve_active are tied 0.
module wb_arb_starve_ctr
   import wb_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic req1_valid,
   input  logic req1_ready,
   output logic force1,
   output logic starve_active
);

`ifdef WB_ARB_STARVE_EN

   localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(STARVE_LIMIT);

   arb_state_t            state;
   arb_state_t            state_nxt;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
   logic [WAIT_CNT_W-1:0] wait_inc;

   function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] c);
      return (c == WAIT_CNT_MAX) ? c : c + 1'b1;
   endfunction

   assign wait_inc = sat_inc(wait_cnt);

   // A loss only happens in NORMAL; in FORCE1 a valid req1 is always granted.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      if (!req1_valid || req1_ready) begin
         wait_cnt_nxt = '0;
         state_nxt    = NORMAL;
      end else begin
         wait_cnt_nxt = wait_inc;
         if (state == NORMAL && wait_inc == LIMIT)
            state_nxt = FORCE1;
      end
   end

   always_ff @(negedge clk or negedge clr) begin
      if (!clr) begin
         state    <= NORMAL;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   assign force1        = (state == FORCE1);
   assign starve_active = force1;

`else

   logic unused_ok;
   assign unused_ok     = &{1'b0, clk, clr, req1_valid, req1_ready, (STARVE_LIMIT > 0)};
   assign force1        = 1'b0;
   assign starve_active = 1'b0;

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter, falling-edge clocked, 1-cycle write latency.
// req0 has fixed priority; WB_ARB_STARVE_EN adds forced req1 grants after STARVE_LIMIT losses.
module regfile_wb_arbiter
   import wb_arb_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              wb_we,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              starve_active
);

   logic              force1;
   logic              grant0_p0;
   logic              grant1_p0;
   logic              xfer_p0;
   logic              zero_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [DATA_W-1:0] data_p0;

   // Stage p0: grant from valids and state only; clr gating keeps readies low in reset.
   assign grant0_p0  = clr & req0_valid & ~force1;
   assign grant1_p0  = clr & req1_valid & (force1 | ~req0_valid);
   assign req0_ready = grant0_p0;
   assign req1_ready = grant1_p0;

   assign xfer_p0 = grant0_p0 | grant1_p0;
   assign addr_p0 = grant0_p0 ? req0_addr : req1_addr;
   assign data_p0 = grant0_p0 ? req0_data : req1_data;
   assign zero_p0 = (addr_p0 == '0);

   wb_arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk           (clk),
      .clr           (clr),
      .req1_valid    (req1_valid),
      .req1_ready    (grant1_p0),
      .force1        (force1),
      .starve_active (starve_active)
   );

   // Stage p1: registered write port; register 0 is hardwired, so its write is suppressed.
   always_ff @(negedge clk or negedge clr) begin
      if (!clr) begin
         wb_we   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
      end else begin
         wb_we <= xfer_p0 & ~zero_p0;
         if (xfer_p0) begin
            wb_addr <= addr_p0;
            wb_data <= data_p0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter against a loss-streak reference model.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int LIM = 4;
`ifdef WB_ARB_STARVE_EN
   localparam bit STARVE_ON = 1'b1;
`else
   localparam bit STARVE_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          clr;
   logic          req0_valid, req1_valid;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [DW-1:0] req0_data, req1_data;
   logic          req0_ready, req1_ready;
   logic          wb_we, starve_active;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: consecutive req1 losses and the expected write-port contents.
   int            streak;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .DATA_W       (DW),
      .ADDR_W       (AW),
      .STARVE_LIMIT (LIM)
   ) dut (
      .clk           (clk),
      .clr           (clr),
      .req0_valid    (req0_valid),
      .req0_addr     (req0_addr),
      .req0_data     (req0_data),
      .req0_ready    (req0_ready),
      .req1_valid    (req1_valid),
      .req1_addr     (req1_addr),
      .req1_data     (req1_data),
      .req1_ready    (req1_ready),
      .wb_we         (wb_we),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .starve_active (starve_active)
   );

   function automatic logic forced_now();
      return STARVE_ON && (streak >= LIM);
   endfunction

   // {req0_ready, req1_ready} expected for the current inputs
   function automatic logic [1:0] exp_rdy();
      logic f;
      f = forced_now();
      return {req0_valid & ~f, req1_valid & (f | ~req0_valid)};
   endfunction

   task automatic model_reset();
      streak = 0;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
   endtask

   task automatic model_edge();
      logic [1:0]    r;
      logic [AW-1:0] a;
      r = exp_rdy();
      a = r[1] ? req0_addr : req1_addr;
      if (req1_valid && !r[0]) streak++;
      else streak = 0;
      m_we = (r != 2'b00) && (a != '0);
      if (r != 2'b00) begin
         m_addr = a;
         m_data = r[1] ? req0_data : req1_data;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         clr = 1'b0;
         req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hA5A5_0009;
         req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0000_4444;
         #1;
         n_cmp++;
         if ({req0_ready, req1_ready, wb_we, starve_active} !== 4'b0000 || wb_addr !== '0 || wb_data !== '0) begin
            n_err++;
            $display("FAIL reset_hold: rdy0=%b rdy1=%b we=%b starve=%b addr=%0d data=%h, required all 0",
                     req0_ready, req1_ready, wb_we, starve_active, wb_addr, wb_data);
         end
         model_reset();
      end
      @(posedge clk);
      clr = 1'b1;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_release: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
      end
      model_edge();
      @(posedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      n_cmp++;
      if (wb_we !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'hA5A5_0009) begin
         n_err++;
         $display("FAIL reset_first_wb: we=%b addr=%0d data=%h, required 1 9 a5a50009", wb_we, wb_addr, wb_data);
      end
      model_edge();
   endtask

   task automatic test_single();
      @(posedge clk);
      req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hDEAD_BEEF;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL single_ready: rdy0=%b rdy1=%b, required 0 1", req0_ready, req1_ready);
      end
      model_edge();
      @(posedge clk);
      req1_valid = 1'b0;
      #1;
      n_cmp++;
      if (wb_we !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL single_wb: we=%b addr=%0d data=%h, required 1 7 deadbeef", wb_we, wb_addr, wb_data);
      end
      model_edge();
   endtask

   task automatic test_contention();
      @(posedge clk);
      req0_valid = 1'b1; req0_addr = 5'd3;  req0_data = 32'h0000_0011;
      req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 32'h00C0_FFEE;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL contention_ready: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
      end
      model_edge();
      @(posedge clk);
      req0_valid = 1'b0;
      #1;
      n_cmp++;
      if (wb_we !== 1'b1 || wb_addr !== 5'd3 || wb_data !== 32'h11 || req1_ready !== 1'b1) begin
         n_err++;
         $display("FAIL contention_wb: we=%b addr=%0d data=%h rdy1=%b, required 1 3 00000011 1",
                  wb_we, wb_addr, wb_data, req1_ready);
      end
      model_edge();
      @(posedge clk);
      req1_valid = 1'b0;
      #1;
      n_cmp++;
      if (wb_we !== 1'b1 || wb_addr !== 5'd12 || wb_data !== 32'h00C0_FFEE) begin
         n_err++;
         $display("FAIL contention_req1_wb: we=%b addr=%0d data=%h, required 1 12 00c0ffee", wb_we, wb_addr, wb_data);
      end
      model_edge();
   endtask

   task automatic test_starvation();
      int   k0;
      logic e1;
      k0 = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         req0_valid = 1'b1; req0_addr = AW'(k0 % 31 + 1); req0_data = 32'h1000 + k0;
         req1_valid = 1'b1; req1_addr = 5'd20; req1_data = 32'h0000_BEEF;
         #1;
         e1 = STARVE_ON && (i % 5 == 4);
         n_cmp++;
         if ({req0_ready, req1_ready, starve_active} !== {~e1, e1, e1}) begin
            n_err++;
            $display("FAIL starve_cycle%0d: rdy0=%b rdy1=%b starve=%b, required %b %b %b",
                     i, req0_ready, req1_ready, starve_active, ~e1, e1, e1);
         end
         n_cmp++;
         if ({wb_we, wb_addr, wb_data} !== {m_we, m_addr, m_data}) begin
            n_err++;
            $display("FAIL starve_wb%0d: we=%b addr=%0d data=%h, required %b %0d %h",
                     i, wb_we, wb_addr, wb_data, m_we, m_addr, m_data);
         end
         if (!e1) k0++;
         model_edge();
      end
   endtask

   task automatic test_zero_reg();
      @(posedge clk);
      req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h0000_0055;
      req1_valid = 1'b0;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL zero_ready: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
      end
      model_edge();
      @(posedge clk);
      req0_valid = 1'b0;
      #1;
      n_cmp++;
      if (wb_we !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'h55) begin
         n_err++;
         $display("FAIL zero_wb: we=%b addr=%0d data=%h, required 0 0 00000055", wb_we, wb_addr, wb_data);
      end
      model_edge();
   endtask

   task automatic test_abort();
      @(posedge clk);
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h0000_5555;
      #1;
      model_edge();
      @(negedge clk);
      #2;
      n_cmp++;
      if (wb_we !== 1'b1 || wb_addr !== 5'd5) begin
         n_err++;
         $display("FAIL abort_pre: we=%b addr=%0d, required 1 5", wb_we, wb_addr);
      end
      clr = 1'b0;
      #1;
      n_cmp++;
      if ({wb_we, req0_ready, req1_ready} !== 3'b000 || wb_addr !== '0 || wb_data !== '0) begin
         n_err++;
         $display("FAIL abort_clear: we=%b rdy0=%b rdy1=%b addr=%0d data=%h, required all 0",
                  wb_we, req0_ready, req1_ready, wb_addr, wb_data);
      end
      model_reset();
      @(posedge clk);
      clr = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h0000_6666;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL abort_release: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
      end
      model_edge();
      @(posedge clk);
      req0_valid = 1'b0;
      #1;
      n_cmp++;
      if (wb_we !== 1'b1 || wb_addr !== 5'd6 || wb_data !== 32'h6666) begin
         n_err++;
         $display("FAIL abort_first_wb: we=%b addr=%0d data=%h, required 1 6 00006666", wb_we, wb_addr, wb_data);
      end
      model_edge();
   endtask

   task automatic test_random();
      bit         pend0, pend1;
      logic [1:0] er;
      pend0 = 1'b0;
      pend1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (!pend0) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            req0_data  = $urandom;
         end
         if (!pend1) begin
            req1_valid = ($urandom_range(0, 4) != 0);
            req1_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            req1_data  = $urandom;
         end
         #1;
         er = exp_rdy();
         n_cmp++;
         if ({req0_ready, req1_ready, starve_active} !== {er, forced_now()}) begin
            n_err++;
            $display("FAIL rand_ready%0d: rdy0=%b rdy1=%b starve=%b, required %b %b %b",
                     i, req0_ready, req1_ready, starve_active, er[1], er[0], forced_now());
         end
         n_cmp++;
         if ({wb_we, wb_addr, wb_data} !== {m_we, m_addr, m_data}) begin
            n_err++;
            $display("FAIL rand_wb%0d: we=%b addr=%0d data=%h, required %b %0d %h",
                     i, wb_we, wb_addr, wb_data, m_we, m_addr, m_data);
         end
         pend0 = req0_valid && !er[1];
         pend1 = req1_valid && !er[0];
         model_edge();
      end
   endtask

   initial begin
      clr = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      model_reset();
      test_reset();
      test_single();
      test_contention();
      test_starvation();
      test_zero_reg();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the write-data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register-address width.
REQ-003 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive lost cycles before req1 is forced to win; legal range 1..15.
REQ-004 clk  in  1  clock; all state SHALL update on the falling edge.
REQ-005 clr  in  1  reset, asynchronous, active-low.
REQ-006 req0_valid  in  1  pipeline writeback request.
REQ-007 req0_addr  in  ADDR_W  destination register for req0.
REQ-008 req0_data  in  DATA_W  write data for req0.
REQ-009 req0_ready  out  1  req0 transfer accepted this cycle.
REQ-010 req1_valid  in  1  multdiv result request.
REQ-011 req1_addr  in  ADDR_W  destination register for req1.
REQ-012 req1_data  in  DATA_W  write data for req1.
REQ-013 req1_ready  out  1  req1 transfer accepted this cycle.
REQ-014 wb_we  out  1  register-file write enable, registered.
REQ-015 wb_addr  out  ADDR_W  register-file write address, registered.
REQ-016 wb_data  out  DATA_W  register-file write data, registered.
REQ-017 starve_active  out  1  high while in FORCE1 state.

Function
REQ-018 A transfer SHALL occur on reqN when reqN_valid and reqN_ready are both high at a falling edge; requesters SHALL hold valid, addr and data stable until ready.
REQ-019 At most one transfer SHALL occur per cycle; readies SHALL be one-hot or zero.
REQ-020 In state NORMAL: req0_ready = req0_valid; req1_ready = req1_valid and not req0_valid.
REQ-021 In state FORCE1: req1_ready = req1_valid; req0_ready = 0.
REQ-022 Readies SHALL be combinational from valids and state; there SHALL be no combinational path from addr or data to any ready.
REQ-023 Each accepted transfer SHALL appear on wb_we/wb_addr/wb_data at the next falling edge (1-cycle latency); wb_we SHALL be 0 on every cycle following a cycle with no transfer.
REQ-024 A transfer to address 0 SHALL complete its handshake normally but SHALL produce wb_we = 0; wb_addr and wb_data still update.
REQ-025 Wait counter wait_cnt (4 bits) SHALL increment when req1_valid is high and req1_ready is low, saturating at 15, and SHALL clear on a req1 transfer or when req1_valid is low.
REQ-026 NORMAL -> FORCE1 SHALL occur at the edge where wait_cnt would reach STARVE_LIMIT; FORCE1 -> NORMAL SHALL occur on the req1 transfer or when req1_valid drops, and wait_cnt SHALL clear at the same time.
REQ-027 When both valids rise in the same cycle in NORMAL, req0 SHALL win.

Reset
REQ-028 While clr is low: state = NORMAL, wait_cnt = 0, wb_we = 0, wb_addr = 0, wb_data = 0, starve_active = 0, both readies = 0.
REQ-029 Assertion of clr mid-transfer SHALL abort the pending registered write (wb_we = 0 immediately); the first transfer after reset release SHALL be accepted on the first falling edge with clr high.

Configuration
REQ-030 With WB_ARB_STARVE_EN defined: FORCE1 state, wait_cnt and starve_active SHALL be implemented as specified.
REQ-031 Without WB_ARB_STARVE_EN: arbitration SHALL be pure fixed priority (REQ-020 always), wait_cnt SHALL not exist, and starve_active SHALL be tied to 0.

Structure
REQ-032 Package wb_arb_pkg SHALL hold the DATA_W/ADDR_W defaults, the arbiter state enum (NORMAL, FORCE1) and the wait-counter width constant.
REQ-033 Sub-module wb_arb_starve_ctr SHALL contain wait_cnt and the NORMAL/FORCE1 state logic; the top holds grant and the output register.

Verification
REQ-034 Reset: clr low with both valids high -> readies 0, wb_we 0; clr high -> req0_ready 1 at first falling edge, wb_we 1 one edge later.
REQ-035 Single: req1 only, addr 7, data 0xDEADBEEF -> req1_ready 1, next cycle wb_we 1, wb_addr 7, wb_data 0xDEADBEEF.
REQ-036 Contention: both valid, req0 addr 3, data 0x11 -> req0 wins; wb_addr 3 next cycle; req1 still waiting.
REQ-037 Starvation (macro on, STARVE_LIMIT 4): req0 and req1 held valid -> req0 wins 4 cycles, cycle 5 req1_ready 1, starve_active 1, req0_ready 0; next cycle NORMAL.
REQ-038 Zero register: req0 addr 0, data 0x55 -> req0_ready 1, next cycle wb_we 0.
REQ-039 Macro off: both valid for 20 cycles -> req1_ready never high, starve_active constant 0.
